// File: rtl/fifo_write_packer.sv
// fifo_write_packer: pairs host bytes into 16-bit words and drives the FIFO write port, write pointer and full flag.
module fifo_write_packer #(
    parameter int ADDRSIZE = 8,
    parameter int DATASIZE = 16
) (
    input  logic                wclk,
    input  logic                wrst,
    input  logic                byte_valid,
    input  logic [7:0]          byte_data,
    output logic                byte_ready,
    input  logic                flush,
    input  logic [ADDRSIZE:0]   wq2_rptr,
    output logic                winc,
    output logic                wfull,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [DATASIZE-1:0] wdata,
    output logic [ADDRSIZE:0]   wptr
);
    typedef enum logic [1:0] {EMPTY, HALF, PUSH} state_t;
    state_t state, state_nxt;
    logic [7:0] lo_byte, lo_nxt;
    logic [DATASIZE-1:0] wdata_nxt;
    logic [ADDRSIZE:0] wbin, wbinnext, wgraynext;
    logic acc;
    assign byte_ready = (state != PUSH) || !wfull;
    assign winc = (state == PUSH) && !wfull;
    assign acc = byte_valid && byte_ready;
    assign waddr = wbin[ADDRSIZE-1:0];
    assign wbinnext = wbin + {{ADDRSIZE{1'b0}}, winc};
    assign wgraynext = (wbinnext >> 1) ^ wbinnext;
    always_comb begin
        state_nxt = state;
        lo_nxt = lo_byte;
        wdata_nxt = wdata;
        case (state)
            EMPTY: if (acc) begin
                lo_nxt = byte_data;
                state_nxt = HALF;
            end
            HALF: if (acc || flush) begin
                wdata_nxt = {acc ? byte_data : 8'h00, lo_byte};
                state_nxt = PUSH;
            end
            PUSH: if (winc) begin
                lo_nxt = acc ? byte_data : lo_byte;
                state_nxt = acc ? HALF : EMPTY;
            end
            default: state_nxt = EMPTY;
        endcase
    end
    always_ff @(posedge wclk) begin
        if (wrst) begin
            state <= EMPTY;
            lo_byte <= '0;
            wdata <= '0;
            wbin <= '0;
            wptr <= '0;
            wfull <= 1'b0;
        end else begin
            state <= state_nxt;
            lo_byte <= lo_nxt;
            wdata <= wdata_nxt;
            wbin <= wbinnext;
            wptr <= wgraynext;
            wfull <= wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};
        end
    end
endmodule
